// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO helpers (Gray conversion, full-compare pattern)
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] n);
    return n ^ (n >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Gray pointer that is exactly one depth ahead of g: top two bits inverted.
  function automatic logic [31:0] full_cmp_pattern(input logic [31:0] g, input int w);
    return g ^ (32'h3 << (w - 2));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop bus synchroniser, synchronous active-high reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      q  <= '0;
    end else begin
      d1 <= d;
      q  <= d1;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side pointer and flag controller (w_clk domain)
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = 12
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   r_gaddr,
  output logic              w_wen,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_gaddr,
  output logic              w_full,
  output logic              w_afull,
  output logic [ADDR_W:0]   w_level,
  output logic              w_overflow
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] bptr;
  logic [PW-1:0] bnext;
  logic [PW-1:0] gnext;
  logic [PW-1:0] rg_d2;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_pat;

  sync_2ff #(.W(PW)) u_rg_sync (
    .clk (w_clk),
    .rst (rst),
    .d   (r_gaddr),
    .q   (rg_d2)
  );

  assign w_wen  = w_en & ~w_full;
  assign w_addr = bptr[ADDR_W-1:0];

  assign bnext      = bptr + PW'(w_wen);
  assign gnext      = PW'(bin2gray(32'(bnext)));
  assign r_bin      = PW'(gray2bin(32'(rg_d2)));
  assign full_pat   = PW'(full_cmp_pattern(32'(rg_d2), PW));
  // Stale rg_d2 can only make this larger than the true occupancy, never smaller.
  assign level_next = bnext - r_bin;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      bptr       <= '0;
      w_gaddr    <= '0;
      w_full     <= 1'b0;
      w_afull    <= 1'b0;
      w_level    <= '0;
      w_overflow <= 1'b0;
    end else begin
      bptr       <= bnext;
      w_gaddr    <= gnext;
      w_full     <= (gnext == full_pat);
      w_afull    <= (int'(level_next) >= AF_THRESH);
      w_level    <= level_next;
      w_overflow <= w_overflow | (w_en & w_full);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - randomized self-checking bench for fifo_wr_ctrl against an occupancy-count model
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic          w_clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic [AW:0]   r_gaddr = '0;
  logic          w_wen;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_gaddr;
  logic          w_full;
  logic          w_afull;
  logic [AW:0]   w_level;
  logic          w_overflow;

  fifo_wr_ctrl #(.ADDR_W(AW), .AF_THRESH(AF)) dut (
    .w_clk      (w_clk),
    .rst        (rst),
    .w_en       (w_en),
    .r_gaddr    (r_gaddr),
    .w_wen      (w_wen),
    .w_addr     (w_addr),
    .w_gaddr    (w_gaddr),
    .w_full     (w_full),
    .w_afull    (w_afull),
    .w_level    (w_level),
    .w_overflow (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: plain write/read counts; rs1/rs2 are the read counts visible through the synchroniser.
  int wcnt = 0;
  int rcnt = 0;
  int rs1 = 0;
  int rs2 = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_afull = 0;
  bit m_ovf = 0;
  logic [AW:0] prev_g = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n % 32);
    return b ^ (b >> 1);
  endfunction

  // One w_clk cycle: drive at a random phase, check w_wen/w_addr just before the edge,
  // advance the model on the edge, check registered outputs 1ns after it.
  task automatic step(input bit en, input bit rv, input int rtarget);
    int  ph;
    int  occ;
    bit  ewen;
    ph = $urandom_range(1, 7);
    #(ph);
    w_en = en;
    rst  = rv;
    rcnt = rv ? 0 : rtarget;
    r_gaddr = gray_of(rcnt);
    #(8 - ph);
    ewen = en && !m_full;
    check("w_wen", 32'(w_wen), 32'(ewen));
    check("w_addr", 32'(w_addr), 32'(wcnt % DEPTH));
    @(posedge w_clk);
    if (rv) begin
      wcnt = 0; rs1 = 0; rs2 = 0; m_level = 0;
      m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      m_ovf   = m_ovf | (en && m_full);
      wcnt    = wcnt + int'(ewen);
      m_level = wcnt - rs2;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AF);
      rs2 = rs1;
      rs1 = rcnt;
    end
    #1;
    check("w_gaddr", 32'(w_gaddr), 32'(gray_of(wcnt)));
    check("w_full", 32'(w_full), 32'(m_full));
    check("w_afull", 32'(w_afull), 32'(m_afull));
    check("w_level", 32'(w_level), 32'(m_level));
    check("w_overflow", 32'(w_overflow), 32'(m_ovf));
    occ = wcnt - rcnt;
    check("level_ge_occ", 32'(int'(w_level) >= occ), 32'd1);
    check("level_le_depth", 32'(int'(w_level) <= DEPTH), 32'd1);
    if (occ == DEPTH) check("full_at_depth", 32'(w_full), 32'd1);
    if (!rv) check("gray_1bit", 32'($countones(prev_g ^ w_gaddr) <= 1), 32'd1);
    prev_g = w_gaddr;
  endtask

  function automatic int rand_read();
    if (rcnt < wcnt && $urandom_range(0, 1) == 1) return rcnt + 1;
    return rcnt;
  endfunction

  initial begin
    int target;
    int guard;
    @(posedge w_clk);
    #1;

    // Reset held with w_en low, then idle.
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("rst_gaddr", 32'(w_gaddr), 32'd0);
    check("rst_level", 32'(w_level), 32'd0);
    for (int i = 0; i < 2; i++) step(0, 0, 0);
    check("idle_full", 32'(w_full), 32'd0);

    // Fill with no reads.
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0);
      if (i == 11) check("afull_w11", 32'(w_afull), 32'd0);
      if (i == 12) check("afull_w12", 32'(w_afull), 32'd1);
      if (i == 15) check("full_w15", 32'(w_full), 32'd0);
      if (i == 16) begin
        check("full_w16", 32'(w_full), 32'd1);
        check("gaddr_w16", 32'(w_gaddr), 32'b11000);
      end
      if (i == 17) check("ovf_c17", 32'(w_overflow), 32'd1);
    end
    check("fill_level", 32'(w_level), 32'd16);

    // Drain recovery.
    for (int i = 0; i < 3; i++) step(0, 0, 4);
    check("drain_full", 32'(w_full), 32'd0);
    check("drain_level12", 32'(w_level), 32'd12);
    check("drain_afull12", 32'(w_afull), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 5);
    check("drain_level11", 32'(w_level), 32'd11);
    check("drain_afull11", 32'(w_afull), 32'd0);

    // Wrap: 40 more writes interleaved with reads.
    target = wcnt + 40;
    guard = 0;
    while (wcnt < target && guard < 2000) begin
      step($urandom_range(0, 3) != 0, 0, rand_read());
      guard++;
    end
    check("wrap_done", 32'(wcnt >= target), 32'd1);

    // Mid-operation reset at level 9 with overflow set.
    guard = 0;
    while (!m_full && guard < 100) begin
      step(1, 0, rcnt);
      guard++;
    end
    step(1, 0, rcnt);
    for (int i = 0; i < 3; i++) step(0, 0, wcnt - 9);
    check("pre_rst_level", 32'(w_level), 32'd9);
    check("pre_rst_ovf", 32'(w_overflow), 32'd1);
    step(0, 1, 0);
    check("mid_rst_level", 32'(w_level), 32'd0);
    check("mid_rst_ovf", 32'(w_overflow), 32'd0);
    check("mid_rst_addr", 32'(w_addr), 32'd0);
    step(1, 0, 0);
    check("post_rst_gaddr", 32'(w_gaddr), 32'd1);

    // Long random run with random-phase read pointer steps.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 2) != 0, 0, rand_read());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
